nn_layer_engine: RTL and testbench
==================================

NN_LAYER_ENGINE -- requirements
Module: nn_layer_engine

Interface
- REQ-001 Parameters:
  - N_IN, default 4, number of layer inputs.
  - N_OUT, default 6, number of neurons.
  - XW, default 9, signed input width.
  - WW, default 8, signed weight width.
  - YMAX, default 1, activation saturation magnitude.
- REQ-002 Ports, clock and reset first:
  - clk, in, 1, clock.
  - reset, in, 1, synchronous, active-high reset.
  - in_valid, in, 1, input vector offered.
  - in_ready, out, 1, engine can accept.
  - x, in, N_IN*XW, packed signed inputs; element i at [i*XW +: XW].
  - w_addr, out, clog2(N_IN*N_OUT), weight read address.
  - w_rdata, in, WW, signed weight; valid exactly 1 cycle after w_addr.
  - out_valid, out, 1, results held.
  - out_ready, in, 1, consumer accepts.
  - y, out, N_OUT*XW, packed signed activations.
  - dy, out, N_OUT, activation derivative bits (DERIV feature only).

Function
- REQ-003 FSM has four states: IDLE, ISSUE, DRAIN, HOLD; in_ready=1 only in IDLE.
- REQ-004 IDLE with in_valid=1: SHALL latch x, clear all accumulators, go to ISSUE.
- REQ-005 ISSUE SHALL drive w_addr = j*N_IN+i, incrementing by 1 per cycle from 0 to N_IN*N_OUT-1, i fastest; after the last address the FSM goes to DRAIN.
- REQ-006 Each cycle after an address is issued, acc[j] += x[i]*w_rdata (signed), using the (i,j) registered with that address.
- REQ-007 Accumulator width ACCW = XW+WW+clog2(N_IN); accumulation SHALL never overflow and SHALL NOT saturate.
- REQ-008 DRAIN (1 cycle) SHALL absorb the final product, then compute y[j] = clamp(acc[j]>>>1, -YMAX, +YMAX), sign-extended to XW, registered; go to HOLD.
- REQ-009 Arithmetic shift SHALL round toward minus infinity (acc=-3 gives -2, clamped to -YMAX).
- REQ-010 HOLD: out_valid=1; y and dy stable until out_valid&&out_ready; then go to IDLE.
- REQ-011 Latency from the accept cycle to first out_valid SHALL be N_IN*N_OUT+2 cycles.
- REQ-012 x changes after acceptance SHALL NOT affect results.
- REQ-013 w_addr SHALL hold its last value outside ISSUE.
- REQ-014 in_valid during ISSUE/DRAIN/HOLD is ignored; there is no back-to-back acceptance in the HOLD exit cycle.

Reset
- REQ-015 reset SHALL force IDLE and clear accumulators: in_ready=1, out_valid=0, y=0, dy=0, w_addr=0.
- REQ-016 reset asserted mid-ISSUE/DRAIN/HOLD SHALL abort immediately with no partial out_valid; the next accept starts clean.

Configuration
- REQ-017 Macro NN_LAYER_DERIV_EN:
  - Defined: dy[j]=1 iff -YMAX < (acc[j]>>>1) < +YMAX, else 0; registered with y.
  - Undefined: dy tied to 0 and no derivative logic is present.

Structure
- REQ-018 Package nn_pkg SHALL hold:
  - the FSM state enum;
  - the clog2 helper;
  - the shared default constants XW=9, WW=8, YMAX=1.
- REQ-019 One sub-module, nn_sat_act: combinational clamp plus derivative, instantiated N_OUT times.

Verification
- REQ-020 N_IN=4, N_OUT=2, x={1,1,1,1}, all weights 1 -> acc=4, y={1,1}, dy={0,0}; out_valid exactly 10 cycles after accept.
- REQ-021 x={1,0,0,0}, w[0]=1, others 0 -> acc0=1, y0=0, dy0=1; neuron 1: acc=0, y=0, dy=1.
- REQ-022 x={-255,...}, w=-128 everywhere -> no overflow; acc=130560 per neuron; y=+1.
- REQ-023 out_ready held 0 for 5 cycles in HOLD -> y stable, out_valid=1, in_ready=0; release -> IDLE next cycle.
- REQ-024 Assert reset at ISSUE cycle 3 -> next cycle in_ready=1, out_valid=0; a new vector gives correct results with no stale accumulation.
- REQ-025 Build without NN_LAYER_DERIV_EN -> dy=0 for every case above; y unchanged.

Source files
------------

// File: rtl/nn_pkg.sv
// ============================================================================
// Module : nn_pkg
// Brief  : Shared types, defaults and helpers for the neural layer engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package nn_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      HOLD  = 2'd3
   } nn_state_t;

   localparam int c_XW   = 9;
   localparam int c_WW   = 8;
   localparam int c_YMAX = 1;

   function automatic int nn_clog2(input int value);
      int result;
      int v;
      result = 0;
      v      = value - 1;
      while (v > 0) begin
         result = result + 1;
         v      = v >> 1;
      end
      return result;
   endfunction

endpackage

`default_nettype wire

// File: rtl/nn_sat_act.sv
// ============================================================================
// Module : nn_sat_act
// Brief  : Halving saturating activation with optional derivative flag
//          (derivative output present only with NN_LAYER_DERIV_EN).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_sat_act
   import nn_pkg::*;
#(
   parameter int ACCW = 19,
   parameter int XW   = c_XW,
   parameter int YMAX = c_YMAX
) (
   input  logic signed [ACCW-1:0] acc,
   output logic        [XW-1:0]   y
`ifdef NN_LAYER_DERIV_EN
   ,
   output logic                   dy
`endif
);

   localparam logic signed [ACCW-1:0] c_POS = ACCW'(YMAX);
   localparam logic signed [ACCW-1:0] c_NEG = -c_POS;

   logic signed [ACCW-1:0] w_half;

   // Arithmetic shift floors toward minus infinity, so -3 becomes -2.
   assign w_half = acc >>> 1;

   always_comb begin
      if (w_half > c_POS) begin
         y = c_POS[XW-1:0];
      end else if (w_half < c_NEG) begin
         y = c_NEG[XW-1:0];
      end else begin
         y = w_half[XW-1:0];
      end
   end

`ifdef NN_LAYER_DERIV_EN
   assign dy = (w_half > c_NEG) && (w_half < c_POS);
`endif

endmodule

`default_nettype wire

// File: rtl/nn_layer_engine.sv
// ============================================================================
// Module : nn_layer_engine
// Brief  : Sequential fully connected layer, one MAC per cycle, with
//          saturating activation; NN_LAYER_DERIV_EN enables the dy outputs.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module nn_layer_engine
   import nn_pkg::*;
#(
   parameter int N_IN  = 4,
   parameter int N_OUT = 6,
   parameter int XW    = c_XW,
   parameter int WW    = c_WW,
   parameter int YMAX  = c_YMAX
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic                              in_valid,
   output logic                              in_ready,
   input  logic [N_IN*XW-1:0]                x,
   output logic [nn_clog2(N_IN*N_OUT)-1:0]   w_addr,
   input  logic [WW-1:0]                     w_rdata,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [N_OUT*XW-1:0]               y,
   output logic [N_OUT-1:0]                  dy
);

   localparam int c_AW   = nn_clog2(N_IN*N_OUT);
   localparam int c_IW   = (N_IN  > 1) ? nn_clog2(N_IN)  : 1;
   localparam int c_JW   = (N_OUT > 1) ? nn_clog2(N_OUT) : 1;
   localparam int c_ACCW = XW + WW + nn_clog2(N_IN);
   localparam logic [c_AW-1:0] c_LAST = c_AW'(N_IN*N_OUT-1);

   nn_state_t                r_state;
   logic                     r_in_ready;
   logic                     r_out_valid;
   logic [c_AW-1:0]          r_addr;
   logic [c_IW-1:0]          r_i;
   logic [c_JW-1:0]          r_j;
   logic                     r_pend_valid;
   logic [c_IW-1:0]          r_pend_i;
   logic [c_JW-1:0]          r_pend_j;
   logic signed [XW-1:0]     r_x        [N_IN];
   logic signed [c_ACCW-1:0] r_acc      [N_OUT];
   logic signed [c_ACCW-1:0] w_acc_next [N_OUT];
   logic [XW-1:0]            w_y        [N_OUT];
   logic [N_OUT*XW-1:0]      r_y;
   logic signed [XW+WW-1:0]  w_prod;
   logic signed [c_ACCW-1:0] w_prod_ext;
   logic                     w_accept;
`ifdef NN_LAYER_DERIV_EN
   logic [N_OUT-1:0]         w_dy;
   logic [N_OUT-1:0]         r_dy;
`endif

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign w_addr    = r_addr;
   assign y         = r_y;

   assign w_accept   = (r_state == IDLE) && in_valid;
   assign w_prod     = r_x[r_pend_i] * $signed(w_rdata);
   assign w_prod_ext = c_ACCW'(w_prod);

   // The pending (i,j) tags the weight returning this cycle.
   for (genvar j = 0; j < N_OUT; j++) begin : g_neuron
      assign w_acc_next[j] = (r_pend_valid && (r_pend_j == c_JW'(j)))
                             ? r_acc[j] + w_prod_ext : r_acc[j];

      nn_sat_act #(
         .ACCW (c_ACCW),
         .XW   (XW),
         .YMAX (YMAX)
      ) u_act (
         .acc (w_acc_next[j]),
         .y   (w_y[j])
`ifdef NN_LAYER_DERIV_EN
         ,
         .dy  (w_dy[j])
`endif
      );
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_in_ready   <= 1'b1;
         r_out_valid  <= 1'b0;
         r_addr       <= '0;
         r_i          <= '0;
         r_j          <= '0;
         r_pend_valid <= 1'b0;
         r_pend_i     <= '0;
         r_pend_j     <= '0;
      end else begin
         r_pend_valid <= 1'b0;
         case (r_state)
            IDLE: begin
               if (in_valid) begin
                  r_state    <= ISSUE;
                  r_in_ready <= 1'b0;
                  r_addr     <= '0;
                  r_i        <= '0;
                  r_j        <= '0;
               end
            end
            ISSUE: begin
               r_pend_valid <= 1'b1;
               r_pend_i     <= r_i;
               r_pend_j     <= r_j;
               if (r_addr == c_LAST) begin
                  r_state <= DRAIN;
               end else begin
                  r_addr <= r_addr + c_AW'(1);
                  if (r_i == c_IW'(N_IN-1)) begin
                     r_i <= '0;
                     r_j <= r_j + c_JW'(1);
                  end else begin
                     r_i <= r_i + c_IW'(1);
                  end
               end
            end
            DRAIN: begin
               r_state     <= HOLD;
               r_out_valid <= 1'b1;
            end
            HOLD: begin
               if (out_ready) begin
                  r_state     <= IDLE;
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int j = 0; j < N_OUT; j++) begin
            r_acc[j] <= '0;
         end
         for (int i = 0; i < N_IN; i++) begin
            r_x[i] <= '0;
         end
         r_y <= '0;
      end else begin
         if (w_accept) begin
            for (int i = 0; i < N_IN; i++) begin
               r_x[i] <= x[i*XW +: XW];
            end
            for (int j = 0; j < N_OUT; j++) begin
               r_acc[j] <= '0;
            end
         end else begin
            for (int j = 0; j < N_OUT; j++) begin
               r_acc[j] <= w_acc_next[j];
            end
         end
         // DRAIN sees the final product through w_acc_next in the same cycle.
         if (r_state == DRAIN) begin
            for (int j = 0; j < N_OUT; j++) begin
               r_y[j*XW +: XW] <= w_y[j];
            end
         end
      end
   end

`ifdef NN_LAYER_DERIV_EN
   always_ff @(posedge clk) begin
      if (reset) begin
         r_dy <= '0;
      end else if (r_state == DRAIN) begin
         r_dy <= w_dy;
      end
   end
   assign dy = r_dy;
`else
   assign dy = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_nn_layer_engine.sv
// ============================================================================
// Module : tb_nn_layer_engine
// Brief  : Self-checking bench for nn_layer_engine (N_IN=4, N_OUT=2).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_nn_layer_engine;

   localparam int c_NI = 4;
   localparam int c_NO = 2;
   localparam int c_XW = 9;
   localparam int c_WW = 8;
   localparam int c_YM = 1;

   logic                  clk;
   logic                  reset;
   logic                  in_valid;
   logic                  in_ready;
   logic [c_NI*c_XW-1:0]  x;
   logic [2:0]            w_addr;
   logic [c_WW-1:0]       w_rdata;
   logic                  out_valid;
   logic                  out_ready;
   logic [c_NO*c_XW-1:0]  y;
   logic [c_NO-1:0]       dy;

   int tests;
   int failed;
   int xv [c_NI];
   int wv [c_NI*c_NO];
   logic [c_WW-1:0] w_mem [c_NI*c_NO];

   nn_layer_engine #(
      .N_IN  (c_NI),
      .N_OUT (c_NO),
      .XW    (c_XW),
      .WW    (c_WW),
      .YMAX  (c_YM)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .x         (x),
      .w_addr    (w_addr),
      .w_rdata   (w_rdata),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .y         (y),
      .dy        (dy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Weight memory with one cycle read latency.
   always @(posedge clk) w_rdata <= w_mem[w_addr];

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int floor_half(input int a);
      if (a >= 0) return a / 2;
      return -((-a + 1) / 2);
   endfunction

   task automatic model(output logic [c_NO*c_XW-1:0] ey, output logic [c_NO-1:0] edy);
      int acc;
      int h;
      int yy;
      ey  = '0;
      edy = '0;
      for (int j = 0; j < c_NO; j++) begin
         acc = 0;
         for (int i = 0; i < c_NI; i++) acc += xv[i] * wv[j*c_NI + i];
         h  = floor_half(acc);
         yy = (h > c_YM) ? c_YM : ((h < -c_YM) ? -c_YM : h);
         ey[j*c_XW +: c_XW] = c_XW'(yy);
`ifdef NN_LAYER_DERIV_EN
         edy[j] = (h > -c_YM) && (h < c_YM);
`endif
      end
   endtask

   task automatic garbage_x();
      for (int i = 0; i < c_NI; i++) x[i*c_XW +: c_XW] = c_XW'($urandom);
   endtask

   // Offer xv/wv, check latency, results, hold behaviour and return to idle.
   task automatic run_vec(input string tag, input int hold, input bit keep_valid);
      logic [c_NO*c_XW-1:0] ey;
      logic [c_NO-1:0]      edy;
      logic [c_NO*c_XW-1:0] y_first;
      int n;
      model(ey, edy);
      for (int k = 0; k < c_NI*c_NO; k++) w_mem[k] = c_WW'(wv[k]);
      @(negedge clk);
      for (int i = 0; i < c_NI; i++) x[i*c_XW +: c_XW] = c_XW'(xv[i]);
      in_valid  = 1'b1;
      out_ready = 1'b0;
      check({tag, ".in_ready_idle"}, 64'(in_ready), 64'd1);
      @(posedge clk);
      #1;
      in_valid = keep_valid;
      garbage_x();
      n = 0;
      while (n < 40) begin
         @(negedge clk);
         n++;
         if (out_valid) break;
         garbage_x();
      end
      check({tag, ".latency"}, 64'(n), 64'd10);
      check({tag, ".y"}, 64'(y), 64'(ey));
      check({tag, ".dy"}, 64'(dy), 64'(edy));
      check({tag, ".w_addr_hold"}, 64'(w_addr), 64'd7);
      y_first = y;
      for (int k = 0; k < hold; k++) begin
         @(negedge clk);
         check({tag, ".hold_y"}, 64'(y), 64'(y_first));
         check({tag, ".hold_flags"}, 64'({out_valid, in_ready}), 64'b10);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      in_valid  = 1'b0;
      @(negedge clk);
      check({tag, ".release"}, 64'({out_valid, in_ready}), 64'b01);
   endtask

   initial begin
      logic saw_valid;
      tests     = 0;
      failed    = 0;
      reset     = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      x         = '0;
      for (int k = 0; k < c_NI*c_NO; k++) w_mem[k] = '0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("rst.in_ready",  64'(in_ready),  64'd1);
      check("rst.out_valid", 64'(out_valid), 64'd0);
      check("rst.y",         64'(y),         64'd0);
      check("rst.dy",        64'(dy),        64'd0);
      check("rst.w_addr",    64'(w_addr),    64'd0);

      // All ones: acc=4 per neuron.
      for (int i = 0; i < c_NI; i++) xv[i] = 1;
      for (int k = 0; k < c_NI*c_NO; k++) wv[k] = 1;
      run_vec("ones", 0, 1'b0);

      // Single nonzero term: acc0=1, acc1=0.
      xv = '{1, 0, 0, 0};
      for (int k = 0; k < c_NI*c_NO; k++) wv[k] = 0;
      wv[0] = 1;
      run_vec("single", 0, 1'b0);

      // Extreme magnitudes: acc=130560 per neuron.
      for (int i = 0; i < c_NI; i++) xv[i] = -255;
      for (int k = 0; k < c_NI*c_NO; k++) wv[k] = -128;
      run_vec("extreme", 0, 1'b0);

      // Negative odd accumulation: acc=-3 floors to -2, clamped.
      xv = '{-3, 0, 0, 0};
      wv = '{1, 0, 0, 0, 0, 0, 0, 0};
      run_vec("neg_odd", 0, 1'b0);

      // Backpressure for 5 cycles with in_valid held high throughout.
      xv = '{2, -1, 1, 0};
      wv = '{1, 1, 0, 0, -1, 0, 0, 0};
      run_vec("hold5", 5, 1'b1);

      // Reset mid-ISSUE, then a clean vector.
      for (int k = 0; k < c_NI*c_NO; k++) w_mem[k] = 8'd100;
      @(negedge clk);
      for (int i = 0; i < c_NI; i++) x[i*c_XW +: c_XW] = 9'd200;
      in_valid = 1'b1;
      @(posedge clk);
      #1 in_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort.flags", 64'({out_valid, in_ready}), 64'b01);
      saw_valid = 1'b0;
      repeat (12) begin
         @(negedge clk);
         saw_valid = saw_valid | out_valid;
      end
      check("abort.no_valid", 64'(saw_valid), 64'd0);
      xv = '{0, 1, 0, 0};
      wv = '{0, 1, 0, 0, 0, 0, 0, 0};
      run_vec("after_abort", 0, 1'b0);

      // Randomized vectors, alternating full range and near-zero ranges.
      for (int r = 0; r < 16; r++) begin
         for (int i = 0; i < c_NI; i++)
            xv[i] = (r % 2 == 0) ? int'($urandom_range(0, 511)) - 256
                                 : int'($urandom_range(0, 4)) - 2;
         for (int k = 0; k < c_NI*c_NO; k++)
            wv[k] = (r % 2 == 0) ? int'($urandom_range(0, 255)) - 128
                                 : int'($urandom_range(0, 2)) - 1;
         run_vec($sformatf("rand%0d", r), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule

`default_nettype wire
